// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle for pipe_reg_skid: upstream (in_*) and downstream (out_*) valid/ready/data.
interface pipe_reg_skid_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register: 2-entry skid buffer, registered in_ready, synchronous flush.
// Optional PIPE_REG_SKID_STALLCNT_EN adds a saturating downstream-stall cycle counter.
module pipe_reg_skid #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        flush,
`ifdef PIPE_REG_SKID_STALLCNT_EN
  input  logic        stall_cnt_clr,
  output logic [31:0] stall_cnt,
`endif
  pipe_reg_skid_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             occupied;
  logic             in_fire;
  logic             out_fire;

  assign occupied = (state_q != EMPTY);
  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = occupied && bus.out_ready;

  assign bus.out_valid = occupied;
  assign bus.out_data  = main_q;
  assign bus.in_ready  = in_ready_q;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:  if (out_fire) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath and in_ready next values; data registers are left untouched on flush
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = (state_d != FULL);
    if (!flush) begin
      case (state_q)
        EMPTY: if (in_fire) main_d = bus.in_data;
        BUSY: begin
          if (in_fire && out_fire) main_d = bus.in_data;
          else if (in_fire)        skid_d = bus.in_data;
        end
        FULL:  if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_REG_SKID_STALLCNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the head is held by downstream
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = 32'd0;
    end else if (occupied && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid: vector table, queue scoreboard, reset/flush/random sequences.
module tb_pipe_reg_skid;

  localparam int unsigned W = 8;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         rdy;
    logic         ov;
    logic [W-1:0] od;
  } vec_t;

  logic clk = 1'b0;
  logic clrn;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] m_q[$];
  logic         m_rdy;
  vec_t         tbl[23];

  always #5 clk = ~clk;

  pipe_reg_skid_if #(.WIDTH(W)) bus ();

`ifdef PIPE_REG_SKID_STALLCNT_EN
  logic        stall_cnt_clr;
  logic [31:0] stall_cnt;
`endif

  pipe_reg_skid #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .flush         (flush),
`ifdef PIPE_REG_SKID_STALLCNT_EN
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt),
`endif
    .bus           (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the queue model, then advance the model at the edge
  task automatic apply_now(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk(ordy ? "sb_pop" : "hold_data", 32'(bus.out_data), 32'(m_q[0]));
    @(posedge clk);
    if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
    if (fl) m_q.delete();
    else if (iv && m_rdy) m_q.push_back(id);
    m_rdy = (m_q.size() < 2);
  endtask

  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    @(negedge clk);
    apply_now(iv, id, ordy, fl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          iv    id     ordy  fl    rdy   ov    od
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33};
    tbl[4]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[6]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[7]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[8]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[9]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB0};
    tbl[14] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[16] = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[17] = '{1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC0};
    tbl[18] = '{1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[21] = '{1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[22] = '{1'b1, 8'hD1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hD0};

    clrn          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b0;
    m_rdy         = 1'b0;
`ifdef PIPE_REG_SKID_STALLCNT_EN
    stall_cnt_clr = 1'b0;
`endif

    // Reset held with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_data", 32'(bus.out_data), 32'd0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    clrn = 1'b1;
    #1 chk("release_in_ready_low", 32'(bus.in_ready), 32'd0);
    apply_now(1'b1, 8'h5A, 1'b1, 1'b0);

    // Streaming, backpressure, flush in FULL, flush with output fire
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
      apply_now(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
    end

    // Async reset between edges while FULL
    @(negedge clk);
    chk("pre_async_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_async_in_ready", 32'(bus.in_ready), 32'd0);
    #2 clrn = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("async_out_data", 32'(bus.out_data), 32'd0);
    m_q.delete();
    m_rdy = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    apply_now(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef PIPE_REG_SKID_STALLCNT_EN
    stall_cnt_clr = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    stall_cnt_clr = 1'b0;
    @(negedge clk);
    #1 chk("stall_cnt_cleared", stall_cnt, 32'd0);
    apply_now(1'b1, 8'hE0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("stall_cnt_five", stall_cnt, 32'd5);
    stall_cnt_clr = 1'b1;
    apply_now(1'b0, 8'h00, 1'b0, 1'b0);
    stall_cnt_clr = 1'b0;
    @(negedge clk);
    #1 chk("stall_cnt_clr", stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
